// File: rtl/set_max_delay_pkg.sv
// Shared types and defaults for the set_max_delay response buffer.
package set_max_delay_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/set_max_delay_fifo.sv
// Storage, wrapping pointers and occupancy count for the response buffer.
module set_max_delay_fifo
  import set_max_delay_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        pushData_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        headData_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pushOk;
  logic              popOk;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign pushOk     = push_i && !full_o;
  assign popOk      = pop_i && (count_q != '0);
  assign headData_o = mem[rdPtr_q];
  assign count_o    = count_q;

  // DEPTH is a power of two, so plain increment wraps DEPTH-1 back to 0.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popOk)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/set_max_delay_resp.sv
// Responder with FIFO buffer and a registered output stage holding data and its inverse.
// SDC example: set_max_delay -from in_data -through u_fifo -to out_data 5
module set_max_delay_resp
  import set_max_delay_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [DATA_W-1:0]        out_inv,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  state_e            state_q, state_d;
  logic              pop;
  logic              fifoFull;
  logic [DATA_W-1:0] headData;
  logic [DATA_W-1:0] outData_q;
  logic [DATA_W-1:0] outInv_q;

  // Full is decoded from the FIFO count register, keeping out_ready off this path.
  assign in_ready  = !fifoFull;
  assign out_valid = (state_q == HOLD);
  assign out_data  = outData_q;
  assign out_inv   = outInv_q;

  set_max_delay_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (in_valid),
    .pushData_i (in_data),
    .pop_i      (pop),
    .headData_o (headData),
    .count_o    (count),
    .full_o     (fifoFull)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (count != '0) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Data and inverse load together so downstream never sees them disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_q <= '0;
      outInv_q  <= '1;
    end else if (pop) begin
      outData_q <= headData;
      outInv_q  <= ~headData;
    end
  end

endmodule
